// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the multi-port register file.
//   DATA_WIDTH, ADDRESS_WIDTH, NUM_REGS, NR, NW : default parameter values
//   clr_state_e                                 : clear engine state encoding
package regfile_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;
  localparam int NUM_REGS      = 32;
  localparam int NR            = 2;
  localparam int NW            = 2;

  typedef enum logic {CLR_IDLE, CLR_ACTIVE} clr_state_e;
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequential clear engine. It zeroes entries
// 1..NUM_REGS-1, one per cycle, starting the edge after clr_req_i is seen.
//   clk, rst    : clock, async active-high reset
//   clr_req_i   : start a clear (ignored while one is running)
//   clr_busy_o  : clear in progress
//   clr_we_o    : clear write strobe for the storage array
//   clr_addr_o  : entry cleared at the next edge
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
  parameter int NUM_REGS      = regfile_pkg::NUM_REGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     clr_we_o,
  output logic [ADDRESS_WIDTH-1:0] clr_addr_o
);
  localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(NUM_REGS - 1);

  clr_state_e               state_q;
  logic [ADDRESS_WIDTH-1:0] ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          // x0 needs no clearing, so the sweep starts at entry 1
          if (clr_req_i) begin
            state_q <= CLR_ACTIVE;
            ptr_q   <= ADDRESS_WIDTH'(1);
          end
        end
        CLR_ACTIVE: begin
          ptr_q <= ptr_q + ADDRESS_WIDTH'(1);
          if (ptr_q == LAST) state_q <= CLR_IDLE;
        end
        default: state_q <= CLR_IDLE;
      endcase
    end
  end

  // Outputs come straight from state registers
  assign clr_busy_o = (state_q == CLR_ACTIVE);
  assign clr_we_o   = (state_q == CLR_ACTIVE);
  assign clr_addr_o = ptr_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NR-read / NW-write integer register file, x0 hardwired to 0,
// with a sequential clear engine.
//   clk, rst     : clock, async active-high reset (zeroes the file)
//   we_i         : per-write-port enable
//   waddr_i      : per-write-port address
//   wdata_i      : per-write-port data
//   raddr_i      : per-read-port address
//   rdata_o      : per-read-port data (combinational)
//   clr_req_i    : request a whole-file clear
//   clr_busy_o   : clear engine active; writes are dropped
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
  parameter int NUM_REGS      = regfile_pkg::NUM_REGS,
  parameter int NR            = regfile_pkg::NR,
  parameter int NW            = regfile_pkg::NW
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NW-1:0]                          we_i,
  input  logic [NW-1:0][ADDRESS_WIDTH-1:0]       waddr_i,
  input  logic [NW-1:0][DATA_WIDTH-1:0]          wdata_i,
  input  logic [NR-1:0][ADDRESS_WIDTH-1:0]       raddr_i,
  output logic [NR-1:0][DATA_WIDTH-1:0]          rdata_o,
  input  logic                                   clr_req_i,
  output logic                                   clr_busy_o
);
  logic                     clr_we;
  logic [ADDRESS_WIDTH-1:0] clr_addr;

  // No storage for x0; reads of it fall through to the zero default
  logic [DATA_WIDTH-1:0] mem_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] mem_d [1:NUM_REGS-1];

  regfile_clr_fsm #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_REGS     (NUM_REGS)
  ) u_clr (
    .clk       (clk),
    .rst       (rst),
    .clr_req_i (clr_req_i),
    .clr_busy_o(clr_busy_o),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  // Per-entry address match keeps every index in range; out-of-range and x0
  // addresses simply never match. Later ports overwrite earlier ones, so the
  // highest-indexed enabled port wins a conflict.
  always_comb begin
    mem_d = mem_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (clr_we) begin
        if (clr_addr == ADDRESS_WIDTH'(r)) mem_d[r] = '0;
      end else begin
        for (int w = 0; w < NW; w++)
          if (we_i[w] && waddr_i[w] == ADDRESS_WIDTH'(r)) mem_d[r] = wdata_i[w];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NR; p++) begin
      for (int r = 1; r < NUM_REGS; r++)
        if (raddr_i[p] == ADDRESS_WIDTH'(r)) rdata_o[p] = mem_q[r];
`ifdef REGFILE_BYPASS_EN
      if (!clr_busy_o && !rst && raddr_i[p] != '0 && 32'(raddr_i[p]) < NUM_REGS) begin
        for (int w = 0; w < NW; w++)
          if (we_i[w] && waddr_i[w] == raddr_i[p]) rdata_o[p] = wdata_i[w];
      end
`endif
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  import regfile_pkg::*;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;

  typedef logic [NW-1:0][AW-1:0] wa_t;
  typedef logic [NW-1:0][DW-1:0] wd_t;
  typedef logic [NR-1:0][AW-1:0] ra_t;
  typedef logic [NR-1:0][DW-1:0] rd_t;

  typedef struct {
    int         id;
    ra_t        ra;
    rd_t        rd;
    logic       busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NW-1:0] we_i = '0;
  wa_t           waddr_i = '0;
  wd_t           wdata_i = '0;
  ra_t           raddr_i = '0;
  rd_t           rdata_o;
  logic          clr_req_i = 1'b0;
  logic          clr_busy_o;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we_i),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .raddr_i   (raddr_i),
    .rdata_o   (rdata_o),
    .clr_req_i (clr_req_i),
    .clr_busy_o(clr_busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of register values plus "next entry to
  // clear" (0 = no clear running).
  logic [DW-1:0] model [NUM_REGS];
  int            clr_next = 0;
  int            cyc_id = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  exp_t          sbq[$];

  function automatic logic [DW-1:0] mread(input int a);
    if (a == 0 || a >= NUM_REGS) return '0;
    return model[a];
  endfunction

  task automatic op(input bit r, input bit we0, input int a0, input logic [31:0] d0,
                    input bit we1, input int a1, input logic [31:0] d1,
                    input int r0, input int r1, input bit cr);
    exp_t e;
    logic [NW-1:0] we;
    wa_t wa;
    wd_t wd;
    ra_t ra;
    we = {we1, we0};
    wa = {AW'(a1), AW'(a0)};
    wd = {DW'(d1), DW'(d0)};
    ra = {AW'(r1), AW'(r0)};
    rst = r; we_i = we; waddr_i = wa; wdata_i = wd; raddr_i = ra; clr_req_i = cr;
    if (r) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      clr_next = 0;
    end
    e.id = cyc_id; e.ra = ra; e.busy = (clr_next != 0);
    for (int p = 0; p < NR; p++) begin
      e.rd[p] = mread(int'(ra[p]));
`ifdef REGFILE_BYPASS_EN
      if (!r && clr_next == 0 && ra[p] != 0)
        for (int w = 0; w < NW; w++)
          if (we[w] && wa[w] == ra[p]) e.rd[p] = wd[w];
`endif
    end
    sbq.push_back(e);
    cyc_id++;
    @(posedge clk);
    if (!r) begin
      if (clr_next != 0) begin
        model[clr_next] = '0;
        clr_next++;
        if (clr_next == NUM_REGS) clr_next = 0;
      end else begin
        for (int w = 0; w < NW; w++)
          if (we[w] && wa[w] != 0 && int'(wa[w]) < NUM_REGS) model[int'(wa[w])] = wd[w];
        if (cr) clr_next = 1;
      end
    end
    #1;
  endtask

  task automatic rd2(input int r0, input int r1);
    op(0, 0, 0, 0, 0, 0, 0, r0, r1, 0);
  endtask

  // Monitor: whenever expectations are pending, compare them against what
  // the DUT presents mid-cycle.
  exp_t me;
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      me = sbq.pop_front();
      for (int p = 0; p < NR; p++) begin
        n_cmp++;
        if (rdata_o[p] !== me.rd[p]) begin
          n_err++;
          $display("FAIL rdata[%0d] cyc=%0d raddr=%0d got=%h exp=%h", p, me.id, me.ra[p], rdata_o[p], me.rd[p]);
        end
      end
      n_cmp++;
      if (clr_busy_o !== me.busy) begin
        n_err++;
        $display("FAIL clr_busy cyc=%0d got=%b exp=%b", me.id, clr_busy_o, me.busy);
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    @(posedge clk); #1;
    // reset, then a value that a mid-cycle reset must wipe
    op(1, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    op(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 0);
    rd2(5, 5);
    op(1, 0, 0, 0, 0, 0, 0, 5, 5, 0);
    rd2(5, 5);
    // x0 is never written
    op(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    rd2(0, 0);
    // same-address conflict: port 1 wins
    op(0, 1, 7, 32'h11, 1, 7, 32'h22, 7, 7, 0);
    rd2(7, 7);
    // read of an address being written this cycle
    op(0, 1, 3, 32'hABCD, 0, 0, 0, 3, 3, 0);
    rd2(3, 3);
    // fill x1..x31 with their own index, then clear
    for (int i = 1; i < NUM_REGS; i += 2)
      op(0, 1, i, i, (i + 1 < NUM_REGS), (i + 1 < NUM_REGS) ? i + 1 : 0, i + 1, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 0, 1, 31, 1);
    for (int c = 0; c < NUM_REGS - 1; c++) begin
      if (c < 3) op(0, (c == 5), 9, 32'h99, 0, 0, 0, 1, 31, 0);
      else op(0, (c == 5), 9, 32'h99, 0, 0, 0,
              (c == 6) ? 9 : $urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1), (c == 7));
    end
    for (int i = 0; i < NUM_REGS; i += 2) rd2(i, i + 1);
    // reset in the middle of a clear, then a full clear
    for (int i = 1; i < NUM_REGS; i += 2)
      op(0, 1, i, $urandom, 1, (i + 1) % NUM_REGS, $urandom, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 0, 20, 30, 1);
    for (int c = 0; c < 10; c++) rd2(20, 30);
    op(1, 0, 0, 0, 0, 0, 0, 9, 20, 0);
    for (int i = 0; i < NUM_REGS; i += 2) rd2(i, i + 1);
    for (int i = 1; i < NUM_REGS; i += 2)
      op(0, 1, i, $urandom, 1, (i + 1) % NUM_REGS, $urandom, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < NUM_REGS + 1; c++)
      rd2($urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1));
    // random traffic with occasional clears and resets
    for (int n = 0; n < 400; n++)
      op(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, NUM_REGS - 1), $urandom,
         $urandom_range(0, 1), $urandom_range(0, NUM_REGS - 1), $urandom,
         $urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1), ($urandom_range(0, 39) == 0));
    rd2(0, 0);
    @(negedge clk); #1;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file, successor to the single-write/dual-read register file in the RISC-V datapath. Provides NR asynchronous read ports and NW synchronous write ports. Register x0 is hardwired to zero. A sequential clear engine zeroes the file one entry per cycle on request, without a global reset. Sits between decode (read) and writeback (write), and serves wide-issue or multi-writeback pipeline variants.

## Interface
- DATA_WIDTH, 32: bits per register
- ADDRESS_WIDTH, 5: register address bits
- NUM_REGS, 32: number of registers, ≤ 2^ADDRESS_WIDTH
- NR, 2: number of read ports, ≥1
- NW, 2: number of write ports, ≥1
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- we  input  NW  per-port write enable
- waddr  input  NW×ADDRESS_WIDTH  per-port write address
- wdata  input  NW×DATA_WIDTH  per-port write data
- raddr  input  NR×ADDRESS_WIDTH  per-port read address
- rdata  output  NR×DATA_WIDTH  per-port read data, combinational
- clr_req  input  1  request a sequential clear of the whole file
- clr_busy  output  1  clear engine active; writes are ignored

## Operation
- Reset (rst=1, asynchronous): every register = 0, clear FSM = IDLE, clr_busy = 0, and every rdata = 0.
- Reads: rdata[p] = file[raddr[p]]. The result is 0 when raddr[p] = 0 or raddr[p] ≥ NUM_REGS.
- Writes (IDLE only): for each port with we=1, waddr≠0 and waddr<NUM_REGS, file[waddr] ← wdata at the rising edge.
- Writes to x0 or to out-of-range addresses are discarded silently.
- Write conflict: when ports share an address, the highest-indexed enabled port wins.
- Clear FSM has two states, IDLE and CLEAR, with an index counter ptr of width ADDRESS_WIDTH.
  - IDLE → CLEAR when clr_req=1 at an edge; ptr ← 1.
  - CLEAR: at each edge, file[ptr] ← 0 and ptr ← ptr+1.
  - At the edge where ptr = NUM_REGS-1 is cleared, the FSM returns to IDLE.
  - clr_busy = (state == CLEAR).
- While CLEAR, all we are ignored and clr_req is ignored (no restart, no queueing).
- Reads during CLEAR return current contents: already-cleared entries read 0, others keep their old value.
- rst asserted mid-clear: the FSM returns immediately to IDLE and the whole file is zeroed.

## Timing
- Read latency: 0 cycles, combinational from raddr and file state.
- Write latency: 1 edge. The new value is visible on rdata after the edge, or in the same cycle when bypass is enabled.
- Clear request cycle:
  - clr_req sampled high at edge k; any write presented in that same cycle is still performed at edge k.
  - clr_busy rises after edge k.
  - Register i is cleared at edge k+i.
  - clr_busy falls after edge k+NUM_REGS-1, i.e. it is high for NUM_REGS-1 cycles.
- The first accepted write after a clear is the one presented in the cycle following the fall of clr_busy.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Each read port forwards write data in the same cycle when an enabled write port targets a valid, nonzero raddr[p].
  - The highest-indexed matching port wins.
  - No bypass while clr_busy=1.
- REGFILE_BYPASS_EN undefined: reads return pre-edge contents only (read-before-write).

## Structure
- regfile_pkg holds:
  - the default parameter constants (DATA_WIDTH, ADDRESS_WIDTH, NUM_REGS, NR, NW);
  - the clear-state enum clr_state_e {CLR_IDLE, CLR_ACTIVE}.
- Sub-module regfile_clr_fsm:
  - contains the clear FSM and ptr counter;
  - outputs clr_busy, clr_we and clr_addr;
  - the top level muxes its clear write into the storage array.
- Top level owns the storage array, write arbitration and the read/bypass muxes.

## Test plan
- Reset: load x5 = 0xDEADBEEF, then pulse rst asynchronously mid-cycle → rdata for x5 reads 0 immediately; clr_busy = 0.
- x0: write port 0 with waddr=0, wdata=0xFFFFFFFF → raddr=0 reads 0 on all read ports.
- Conflict: port0 writes x7 = 0x11, port1 writes x7 = 0x22 in the same cycle → x7 reads 0x22.
- Bypass: write x3 = 0xABCD while reading x3 in the same cycle.
  - With REGFILE_BYPASS_EN: reads 0xABCD in that cycle.
  - Without it: reads the old value, then 0xABCD in the next cycle.
- Clear: fill x1..x31 with their own index, then pulse clr_req.
  - clr_busy is high for exactly 31 cycles.
  - x1 reads 0 after the first busy edge while x31 still reads 31.
  - A write to x9 during busy is dropped.
  - All registers read 0 after busy falls.
- Mid-clear reset: assert rst 10 cycles into a clear → clr_busy = 0 and all registers 0 immediately; a subsequent clr_req starts a full 31-cycle clear.
